// File: rtl/sdram_arb_pkg.sv
// Shared state encoding and default widths for the two-port SDRAM arbiter.
package sdram_arb_pkg;

   localparam int BW_BURST_LENGTH_DEF = 4;
   localparam int BW_ADDR_DEF         = 25;
   localparam int BW_DATA_BLOCK_DEF   = 32;
   localparam int BW_TIMEOUT_DEF      = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_MASK  = 2'd2,
      ST_WAIT  = 2'd3
   } state_e;

endpackage

// File: rtl/sdram_arb_rr.sv
// Two-way round-robin pick. On contention the port that did not win last
// time is chosen. last_grant resets to 1 so port 0 wins the first contest.
module sdram_arb_rr (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic [1:0] req_i,
   input  logic       update_i,
   output logic       grant_valid_o,
   output logic       grant_o
);

   logic last_grant_q;

   // Combinational pick from the current requests and the last winner.
   always_comb begin
      grant_valid_o = |req_i;
      if (&req_i) grant_o = ~last_grant_q;
      else        grant_o = req_i[1];
   end

   // Remember the winner whenever the owner actually takes a grant.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i)       last_grant_q <= 1'b1;
      else if (update_i) last_grant_q <= grant_o;
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Arbitrates two requester ports onto a single SDRAM controller command
// interface. One command in flight at a time; a watchdog abandons commands
// whose completion never arrives.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int BW_BURST_LENGTH = BW_BURST_LENGTH_DEF,
   parameter int BW_ADDR         = BW_ADDR_DEF,
   parameter int BW_DATA_BLOCK   = BW_DATA_BLOCK_DEF,
   parameter int BW_TIMEOUT      = BW_TIMEOUT_DEF
) (
   input  logic                       clock_i,
   input  logic                       reset_i,
   input  logic                       p0_req_i,
   input  logic                       p0_rw_i,
   input  logic [BW_BURST_LENGTH-1:0] p0_length_i,
   input  logic [BW_ADDR-1:0]         p0_addr_i,
   input  logic [BW_DATA_BLOCK-1:0]   p0_data_i,
   output logic                       p0_ack_o,
   output logic                       p0_done_o,
   output logic [BW_DATA_BLOCK-1:0]   p0_data_o,
   input  logic                       p1_req_i,
   input  logic                       p1_rw_i,
   input  logic [BW_BURST_LENGTH-1:0] p1_length_i,
   input  logic [BW_ADDR-1:0]         p1_addr_i,
   input  logic [BW_DATA_BLOCK-1:0]   p1_data_i,
   output logic                       p1_ack_o,
   output logic                       p1_done_o,
   output logic [BW_DATA_BLOCK-1:0]   p1_data_o,
   output logic                       sdram_request_o,
   output logic                       sdram_command_o,
   output logic [BW_BURST_LENGTH-1:0] sdram_length_o,
   output logic [BW_ADDR-1:0]         sdram_address_o,
   output logic [BW_DATA_BLOCK-1:0]   sdram_data_o,
   input  logic                       sdram_ready_i,
   input  logic                       sdram_done_i,
   input  logic [BW_DATA_BLOCK-1:0]   sdram_data_i,
   output logic                       error_o
);

   state_e                     state_q;
   logic                       gnt_q;
   logic [BW_TIMEOUT-1:0]      wdog_q, wdog_d;
   logic                       ack0_q, ack1_q, done0_q, done1_q, req_q, cmd_q, err_q;
   logic [BW_BURST_LENGTH-1:0] len_q;
   logic [BW_ADDR-1:0]         addr_q;
   logic [BW_DATA_BLOCK-1:0]   wdata_q, p0_data_q, p1_data_q;
   logic                       grant_valid, grant_idx, grant_en, timeout;

   // A grant is only taken from idle, so the round-robin state advances once per command.
   assign grant_en = (state_q == ST_IDLE) && grant_valid;
   assign wdog_d   = wdog_q + 1'b1;
   assign timeout  = (wdog_d == '1);

   sdram_arb_rr u_rr (
      .clock_i       (clock_i),
      .reset_i       (reset_i),
      .req_i         ({p1_req_i, p0_req_i}),
      .update_i      (grant_en),
      .grant_valid_o (grant_valid),
      .grant_o       (grant_idx)
   );

   // Command FSM; every output is a register so pulses are clean single cycles.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         gnt_q     <= 1'b0;
         wdog_q    <= '0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         done0_q   <= 1'b0;
         done1_q   <= 1'b0;
         req_q     <= 1'b0;
         cmd_q     <= 1'b0;
         err_q     <= 1'b0;
         len_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         p0_data_q <= '0;
         p1_data_q <= '0;
      end else begin
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         req_q   <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (grant_en) begin
                  gnt_q   <= grant_idx;
                  cmd_q   <= grant_idx ? p1_rw_i     : p0_rw_i;
                  len_q   <= grant_idx ? p1_length_i : p0_length_i;
                  addr_q  <= grant_idx ? p1_addr_i   : p0_addr_i;
                  wdata_q <= grant_idx ? p1_data_i   : p0_data_i;
                  ack0_q  <= ~grant_idx;
                  ack1_q  <= grant_idx;
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (sdram_ready_i) begin
                  req_q   <= 1'b1;
                  wdog_q  <= '0;
                  state_q <= ST_MASK;
               end
            end
            // One blind cycle: a done seen here belongs to an older command.
            ST_MASK: begin
               wdog_q  <= wdog_d;
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               wdog_q <= wdog_d;
               if (sdram_done_i) begin
                  done0_q <= ~gnt_q;
                  done1_q <= gnt_q;
                  if (!cmd_q) begin
                     if (gnt_q) p1_data_q <= sdram_data_i;
                     else       p0_data_q <= sdram_data_i;
                  end
                  state_q <= ST_IDLE;
               end else if (timeout) begin
                  err_q   <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign p0_ack_o        = ack0_q;
   assign p1_ack_o        = ack1_q;
   assign p0_done_o       = done0_q;
   assign p1_done_o       = done1_q;
   assign p0_data_o       = p0_data_q;
   assign p1_data_o       = p1_data_q;
   assign sdram_request_o = req_q;
   assign sdram_command_o = cmd_q;
   assign sdram_length_o  = len_q;
   assign sdram_address_o = addr_q;
   assign sdram_data_o    = wdata_q;
   assign error_o         = err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a completion scoreboard.
module tb_sdram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req [2];
   logic        rw  [2];
   logic [3:0]  len [2];
   logic [24:0] addr[2];
   logic [31:0] wd  [2];
   logic        ack [2];
   logic        done[2];
   logic [31:0] rd  [2];
   logic        sreq, scmd, rdy, sdone, err;
   logic [3:0]  slen;
   logic [24:0] saddr;
   logic [31:0] sdat, sdin;

   typedef struct {
      int          port;
      bit          is_rd;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          ack_log[$];
   int          pass_cnt = 0, tot_cnt = 0, fail_cnt = 0;
   int          done_cnt = 0, err_cnt = 0, req_cnt = 0;
   bit          outstanding = 0;
   logic [31:0] mdl[2];

   always #5 clk = ~clk;

   sdram_port_arbiter dut (
      .clock_i(clk), .reset_i(rst),
      .p0_req_i(req[0]), .p0_rw_i(rw[0]), .p0_length_i(len[0]), .p0_addr_i(addr[0]),
      .p0_data_i(wd[0]), .p0_ack_o(ack[0]), .p0_done_o(done[0]), .p0_data_o(rd[0]),
      .p1_req_i(req[1]), .p1_rw_i(rw[1]), .p1_length_i(len[1]), .p1_addr_i(addr[1]),
      .p1_data_i(wd[1]), .p1_ack_o(ack[1]), .p1_done_o(done[1]), .p1_data_o(rd[1]),
      .sdram_request_o(sreq), .sdram_command_o(scmd), .sdram_length_o(slen),
      .sdram_address_o(saddr), .sdram_data_o(sdat), .sdram_ready_i(rdy),
      .sdram_done_i(sdone), .sdram_data_i(sdin), .error_o(err)
   );

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      tot_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctl"}, {ack[0], ack[1], done[0], done[1], sreq, scmd, slen, err}, 0);
      chk({tag, "_data"}, {rd[0], rd[1], saddr, sdat}, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req[i] = 0; rw[i] = 0; len[i] = 0; addr[i] = 0; wd[i] = 0;
      end
      rdy = 0; sdone = 0; sdin = 0;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   // One complete transaction on a single port with a cooperative controller.
   task automatic do_txn(input int p, input logic w, input logic [24:0] a,
                         input logic [31:0] wdat, input logic [31:0] rdat,
                         input int rdy_lo, input int done_dly);
      int rq0;
      rw[p] = w; addr[p] = a; wd[p] = wdat; len[p] = 4'd3;
      rdy = (rdy_lo == 0);
      req[p] = 1'b1;
      step();
      chk("txn_ack", ack[p], 1);
      req[p] = 1'b0;
      chk("txn_cmd", scmd, w);
      chk("txn_addr", saddr, a);
      chk("txn_len", slen, 3);
      if (w) chk("txn_wdata", sdat, wdat);
      rq0 = req_cnt;
      if (rdy_lo > 0) begin
         repeat (rdy_lo) step();
         chk("txn_no_req_while_busy", req_cnt, rq0);
         rdy = 1'b1;
      end
      step();
      chk("txn_sreq", sreq, 1);
      sb.push_back('{p, !w, rdat});
      repeat (done_dly - 1) step();
      sdin = rdat; sdone = 1'b1;
      step();
      sdone = 1'b0;
      chk("txn_done", done[p], 1);
      step();
      chk("txn_one_request", req_cnt, rq0 + 1);
   endtask

   // Scoreboard monitor: pops expected completions and tracks the command in flight.
   always @(negedge clk) begin
      if (rst) begin
         outstanding = 0;
         mdl[0] = 0;
         mdl[1] = 0;
      end else begin
         if (ack[0]) ack_log.push_back(0);
         if (ack[1]) ack_log.push_back(1);
         if (sreq) begin
            chk("req_overlap", outstanding, 0);
            outstanding = 1;
            req_cnt++;
         end
         if (done[0] || done[1]) begin
            done_cnt++;
            outstanding = 0;
            chk("sb_nonempty_at_done", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               mon_e = sb.pop_front();
               chk("done_port", {done[1], done[0]}, mon_e.port == 1 ? 2'b10 : 2'b01);
               if (mon_e.is_rd) mdl[mon_e.port] = mon_e.data;
               chk("p0_data", rd[0], mdl[0]);
               chk("p1_data", rd[1], mdl[1]);
            end
         end
         if (err) begin
            err_cnt++;
            outstanding = 0;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int n, dc;
      // Reset state
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req[i] = 0; rw[i] = 0; len[i] = 0; addr[i] = 0; wd[i] = 0;
      end
      rdy = 0; sdone = 0; sdin = 0;
      step();
      chk_all_zero("reset");
      do_reset();

      // Single read on port 0
      do_txn(0, 1'b0, 25'h000100, 32'h0, 32'hDEADBEEF, 0, 5);
      chk("read_p0_data", rd[0], 32'hDEADBEEF);

      // Both ports request continuously: grants alternate starting at port 0
      do_reset();
      ack_log.delete();
      for (int i = 0; i < 2; i++) begin
         rw[i] = 0; addr[i] = 25'h10 * (i + 1); len[i] = 0;
      end
      rdy = 1; req[0] = 1; req[1] = 1;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (!sreq && n < 10) begin step(); n++; end
         chk("rr_sreq", sreq, 1);
         sb.push_back('{k % 2, 1'b1, 32'hA5A50000 + k});
         step();
         step();
         sdin = 32'hA5A50000 + k; sdone = 1;
         step();
         sdone = 0;
         if (k == 3) begin req[0] = 0; req[1] = 0; end
         chk("rr_done", done[k % 2], 1);
      end
      step();
      chk("rr_ack_count", ack_log.size(), 4);
      for (int k = 0; k < 4 && k < ack_log.size(); k++) chk("rr_order", ack_log[k], k % 2);

      // Port 1 write held off by a not-ready controller; port 1 read data must hold
      do_txn(1, 1'b1, 25'h1ABCDE, 32'hCAFEF00D, 32'h0, 8, 3);
      chk("write_p1_hold", rd[1], 32'hA5A50003);

      // Watchdog expiry: no completion ever arrives
      rw[0] = 0; addr[0] = 25'h200; rdy = 1; req[0] = 1;
      step();
      req[0] = 0;
      step();
      chk("wdog_sreq", sreq, 1);
      dc = done_cnt;
      n = 0;
      while (!err && n < 1100) begin step(); n++; end
      chk("wdog_cycles", n, 1023);
      chk("wdog_no_done", done_cnt, dc);
      step();
      chk("wdog_err_single", err, 0);
      do_txn(1, 1'b0, 25'h300, 32'h0, 32'h12345678, 0, 2);

      // Completion on the same edge the watchdog would expire: completion wins
      rw[0] = 0; addr[0] = 25'h400; req[0] = 1;
      step();
      req[0] = 0;
      step();
      chk("edge_sreq", sreq, 1);
      sb.push_back('{0, 1'b1, 32'h0BADF00D});
      repeat (1022) step();
      sdin = 32'h0BADF00D; sdone = 1;
      step();
      sdone = 0;
      chk("edge_done", done[0], 1);
      chk("edge_no_err", err, 0);

      // Spurious completions in idle and in the masked cycle
      step();
      dc = done_cnt;
      sdin = 32'hFFFFFFFF; sdone = 1;
      step();
      sdone = 0;
      chk("spur_idle", {done[0], done[1]}, 0);
      rw[1] = 0; addr[1] = 25'h500; req[1] = 1;
      step();
      req[1] = 0;
      step();
      chk("spur_sreq", sreq, 1);
      sdin = 32'hFFFFFFFF; sdone = 1;
      step();
      sdone = 0;
      chk("spur_mask", {done[0], done[1]}, 0);
      chk("spur_cnt", done_cnt, dc);
      sb.push_back('{1, 1'b1, 32'h600DDA7A});
      sdin = 32'h600DDA7A; sdone = 1;
      step();
      sdone = 0;
      chk("spur_real_done", done[1], 1);
      step();

      // Reset in the wait state discards the command and restores port-0 priority
      rw[0] = 0; addr[0] = 25'h700; req[0] = 1;
      step();
      req[0] = 0;
      step();
      step();
      dc = done_cnt;
      rst = 1;
      #1;
      chk_all_zero("async_reset");
      step();
      rst = 0;
      sdin = 32'h77777777; sdone = 1;
      step();
      sdone = 0;
      chk("late_done", {done[0], done[1]}, 0);
      chk("late_done_cnt", done_cnt, dc);
      req[0] = 1; req[1] = 1;
      step();
      chk("post_reset_grant", {ack[0], ack[1]}, 2'b10);
      req[0] = 0; req[1] = 0;
      step();

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
